// File: rtl/logic_cmd_issuer.sv
// logic_cmd_issuer: command-side initiator for the 64-bit combinational logic
// unit. Commands are queued in a small FIFO and issued one at a time. The
// operands and select are held in registers while the unit evaluates. The
// result is captured and returned with its tag over a valid/ready handshake.
module logic_cmd_issuer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  // command handshake
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [2:0]       cmd_op,
  input  logic [TAGW-1:0]  cmd_tag,
  // logic unit side
  output logic [WIDTH-1:0] lu_a,
  output logic [WIDTH-1:0] lu_b,
  output logic [2:0]       lu_sel,
  input  logic [WIDTH-1:0] lu_res,
  // response handshake
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_res,
  output logic [TAGW-1:0]  rsp_tag,
  output logic             rsp_zero,
  // status
  output logic             busy,
  output logic [15:0]      op_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = 2 * WIDTH + 3 + TAGW;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic [EW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // issue / response state
  state_t           r_state;
  logic [WIDTH-1:0] r_lu_a;
  logic [WIDTH-1:0] r_lu_b;
  logic [2:0]       r_lu_sel;
  logic [TAGW-1:0]  r_cur_tag;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_res;
  logic [TAGW-1:0]  r_rsp_tag;
  logic             r_rsp_zero;
  logic [15:0]      r_op_count;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_rsp_hs;
  logic [WIDTH-1:0] w_head_a;
  logic [WIDTH-1:0] w_head_b;
  logic [2:0]       w_head_op;
  logic [TAGW-1:0]  w_head_tag;

  // Full/empty come from the registered count only, so cmd_ready never
  // depends on a pop happening in the same cycle.
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign cmd_ready = !w_full && !rst;
  assign w_push    = cmd_valid && cmd_ready;

  // The head entry stays in the FIFO while it is being driven and leaves
  // at the capture edge, so an in-flight command does not occupy a slot
  // once its result is held.
  assign w_pop     = (r_state == S_DRIVE);
  assign w_rsp_hs  = (r_state == S_RESP) && rsp_ready;

  // Head of queue is read asynchronously: it must be loadable onto lu_*
  // in the same cycle the FSM decides to issue.
  assign {w_head_a, w_head_b, w_head_op, w_head_tag} = r_mem[r_rd_ptr];

  // Command storage write; the array carries no reset because emptiness is
  // tracked by the count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_a, cmd_b, cmd_op, cmd_tag};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count
  // unchanged. Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Issue FSM: load operands, let the unit settle for a full cycle,
  // capture the result and hold it until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_lu_a      <= '0;
      r_lu_b      <= '0;
      r_lu_sel    <= '0;
      r_cur_tag   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_res   <= '0;
      r_rsp_tag   <= '0;
      r_rsp_zero  <= 1'b0;
      r_op_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_lu_a    <= w_head_a;
            r_lu_b    <= w_head_b;
            r_lu_sel  <= w_head_op;
            r_cur_tag <= w_head_tag;
            r_state   <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          r_rsp_res   <= lu_res;
          r_rsp_zero  <= (lu_res == '0);
          r_rsp_tag   <= r_cur_tag;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (w_rsp_hs) begin
            r_rsp_valid <= 1'b0;
            r_op_count  <= r_op_count + 16'd1;
            // Head was already popped in DRIVE, so a non-empty FIFO here
            // means a fresh command is waiting.
            if (!w_empty) begin
              r_lu_a    <= w_head_a;
              r_lu_b    <= w_head_b;
              r_lu_sel  <= w_head_op;
              r_cur_tag <= w_head_tag;
              r_state   <= S_DRIVE;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign lu_a      = r_lu_a;
  assign lu_b      = r_lu_b;
  assign lu_sel    = r_lu_sel;
  assign rsp_valid = r_rsp_valid;
  assign rsp_res   = r_rsp_res;
  assign rsp_tag   = r_rsp_tag;
  assign rsp_zero  = r_rsp_zero;
  assign op_count  = r_op_count;
  assign busy      = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_logic_cmd_issuer.sv
// Bench for logic_cmd_issuer: directed commands with hand-computed results;
// expected responses are queued at acceptance and popped by a monitor.
module tb_logic_cmd_issuer;

  localparam int W  = 64;
  localparam int TW = 4;

  typedef struct packed {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
    logic          zero;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [W-1:0]  cmd_a = '0;
  logic [W-1:0]  cmd_b = '0;
  logic [2:0]    cmd_op = '0;
  logic [TW-1:0] cmd_tag = '0;
  logic [W-1:0]  lu_a;
  logic [W-1:0]  lu_b;
  logic [2:0]    lu_sel;
  logic [W-1:0]  lu_res;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [W-1:0]  rsp_res;
  logic [TW-1:0] rsp_tag;
  logic          rsp_zero;
  logic          busy;
  logic [15:0]   op_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_hs = -1;
  bit gap_en  = 0;

  exp_t sb[$];
  exp_t mon_e;
  bit            hold_v = 0;
  logic [W-1:0]  hold_res;
  logic [TW-1:0] hold_tag;
  logic          hold_zero;

  logic [W-1:0] exp_tbl [8];
  logic [W-1:0] va;
  logic [W-1:0] vb;

  logic_cmd_issuer #(.WIDTH(W), .DEPTH(4), .TAGW(TW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .lu_a(lu_a), .lu_b(lu_b), .lu_sel(lu_sel), .lu_res(lu_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_tag(rsp_tag), .rsp_zero(rsp_zero),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // combinational logic unit
  always_comb begin
    lu_res = '0;
    case (lu_sel)
      3'b000: lu_res = lu_a & lu_b;
      3'b001: lu_res = lu_a ^ lu_b;
      3'b010: lu_res = ~(lu_a & lu_b);
      3'b011: lu_res = lu_a | lu_b;
      3'b100: lu_res = ~lu_a;
      3'b101: lu_res = ~(lu_a | lu_b);
      3'b110: lu_res = ~lu_a + 64'd1;
      3'b111: lu_res = ~(lu_a ^ lu_b);
      default: lu_res = '0;
    endcase
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // Monitor: sampled after the falling edge, when all inputs are settled.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      hold_v = 0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 64'(rsp_valid), 64'd1);
        chk("hold_res", rsp_res, hold_res);
        chk("hold_tag", 64'(rsp_tag), 64'(hold_tag));
        chk("hold_zero", 64'(rsp_zero), 64'(hold_zero));
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got tag=%0d res=%h, required no response", rsp_tag, rsp_res);
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_res", rsp_res, mon_e.res);
          chk("rsp_tag", 64'(rsp_tag), 64'(mon_e.tag));
          chk("rsp_zero", 64'(rsp_zero), 64'(mon_e.zero));
          $display("rsp tag=%0d res=%h zero=%0b", rsp_tag, rsp_res, rsp_zero);
        end
        if (gap_en) begin
          if (last_hs >= 0) chk("rsp_gap", 64'(cyc - last_hs), 64'd2);
          last_hs = cyc;
        end
      end
      hold_v    = rsp_valid && !rsp_ready;
      hold_res  = rsp_res;
      hold_tag  = rsp_tag;
      hold_zero = rsp_zero;
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                      input logic [TW-1:0] tag, input logic [W-1:0] res);
    int n;
    exp_t e;
    n = 0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag; cmd_valid = 1'b1;
    #1;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!cmd_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: cmd_ready stayed %0b, required 1 within 100 cycles", cmd_ready);
    end else begin
      @(posedge clk);
      e.res = res; e.tag = tag; e.zero = (res == '0);
      sb.push_back(e);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Wait for the scoreboard to empty, then one more cycle so the last
  // handshake edge has passed; returns at a falling edge.
  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (sb.size() > 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
    end
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    total++;
    bad++;
    $display("FAIL watchdog: simulation still running, required completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic rdy;
    va = 64'hF0F0_F0F0_F0F0_F0F0;
    vb = 64'hFF00_FF00_FF00_FF00;
    exp_tbl[0] = 64'hF000_F000_F000_F000;
    exp_tbl[1] = 64'h0FF0_0FF0_0FF0_0FF0;
    exp_tbl[2] = 64'h0FFF_0FFF_0FFF_0FFF;
    exp_tbl[3] = 64'hFFF0_FFF0_FFF0_FFF0;
    exp_tbl[4] = 64'h0F0F_0F0F_0F0F_0F0F;
    exp_tbl[5] = 64'h000F_000F_000F_000F;
    exp_tbl[6] = 64'h0F0F_0F0F_0F0F_0F10;
    exp_tbl[7] = 64'hF00F_F00F_F00F_F00F;

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("ready_in_reset", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_lu_a", lu_a, 64'd0);
    chk("rst_rsp_res", rsp_res, 64'd0);
    chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
    @(negedge clk);

    // single AND command with latency checks
    send(va, vb, 3'b000, 4'd3, exp_tbl[0]);
    @(negedge clk);
    #1;
    chk("lat_lu_a", lu_a, va);
    chk("lat_lu_b", lu_b, vb);
    chk("lat_lu_sel", 64'(lu_sel), 64'd0);
    chk("lat_valid_c1", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    #1;
    chk("lat_valid_c2", 64'(rsp_valid), 64'd1);
    chk("lat_res", rsp_res, 64'hF000_F000_F000_F000);
    chk("lat_tag", 64'(rsp_tag), 64'd3);
    @(negedge clk);
    #1;
    chk("count_after_1", 64'(op_count), 64'd1);
    @(negedge clk);

    // two's complement edge cases
    send(64'd1, 64'd0, 3'b110, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    send(64'd0, 64'd0, 3'b110, 4'd2, 64'd0);
    drain(50);
    chk("count_after_3", 64'(op_count), 64'd3);

    // all eight ops back to back, full throughput
    do_reset();
    gap_en = 1;
    last_hs = -1;
    for (int i = 0; i < 8; i++) send(va, vb, 3'(i), 4'(i), exp_tbl[i]);
    drain(100);
    gap_en = 0;
    chk("count_after_8", 64'(op_count), 64'd8);
    chk("idle_busy", 64'(busy), 64'd0);

    // backpressure: FIFO plus in-flight command hold DEPTH+1
    rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      if (acc < 6) begin
        cmd_a = va; cmd_b = vb; cmd_op = 3'(acc); cmd_tag = 4'(8 + acc); cmd_valid = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      #1;
      rdy = cmd_ready;
      @(posedge clk);
      if (rdy && cmd_valid) begin
        mon_e.res = exp_tbl[acc]; mon_e.tag = 4'(8 + acc); mon_e.zero = 1'b0;
        sb.push_back(mon_e);
        acc++;
      end
      @(negedge clk);
    end
    #1;
    chk("bp_accepts", 64'(acc), 64'd5);
    chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("bp_rsp_tag", 64'(rsp_tag), 64'd8);
    cmd_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b1;
    drain(100);
    chk("count_after_bp", 64'(op_count), 64'd13);

    // reset while holding a response with three queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(va, vb, 3'(i), 4'(i), exp_tbl[i]);
    repeat (2) @(negedge clk);
    #1;
    chk("pre_rst_valid", 64'(rsp_valid), 64'd1);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    rsp_ready = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_res", rsp_res, 64'd0);
    chk("mid_rst_tag", 64'(rsp_tag), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_count", 64'(op_count), 64'd0);
    chk("mid_rst_ready", 64'(cmd_ready), 64'd1);
    chk("mid_rst_lu_a", lu_a, 64'd0);
    repeat (10) @(negedge clk);
    send(va, vb, 3'b111, 4'd5, exp_tbl[7]);
    drain(50);
    chk("post_rst_count", 64'(op_count), 64'd1);

    // op_count wrap
    force dut.r_op_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_op_count;
    @(negedge clk);
    #1;
    chk("preload_count", 64'(op_count), 64'hFFFF);
    @(negedge clk);
    send(va, vb, 3'b011, 4'd9, exp_tbl[3]);
    drain(50);
    chk("wrap_count", 64'(op_count), 64'd0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_cmd_issuer.md
# logic_cmd_issuer

Command-side initiator for the 64-bit combinational logic unit. It accepts logic operation commands over a valid/ready handshake, buffers them in a small FIFO, and drives operands and select onto the logic unit one command at a time. It captures each result and returns it with its tag over a second valid/ready handshake. It sits between the instruction/control path and the logic unit and provides the registered, flow-controlled boundary the combinational unit lacks.

## Interface
- WIDTH, 64, operand/result width; must match the logic unit
- DEPTH, 4, command FIFO entries; power of two, ≥2
- TAGW, 4, command tag width
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept; = !full && !rst
- cmd_a  in  WIDTH  operand a
- cmd_b  in  WIDTH  operand b
- cmd_op  in  3  operation select, same encoding as the logic unit
- cmd_tag  in  TAGW  opaque tag returned with the result
- lu_a  out  WIDTH  registered operand a to the logic unit
- lu_b  out  WIDTH  registered operand b to the logic unit
- lu_sel  out  3  registered select to the logic unit
- lu_res  in  WIDTH  logic unit result (combinational from lu_a/lu_b/lu_sel)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_res  out  WIDTH  captured result
- rsp_tag  out  TAGW  tag of the command that produced rsp_res
- rsp_zero  out  1  rsp_res == 0
- busy  out  1  state != IDLE or FIFO non-empty
- op_count  out  16  completed responses, wraps

## Operation
- Op encoding (passed through unmodified): 000 AND, 001 XOR, 010 NAND, 011 OR, 100 NOT a, 101 NOR, 110 two's complement of a (~a+1, mod 2^WIDTH), 111 XNOR. All eight codes are valid. No error path exists.
- Push: a command is written to the FIFO tail on each edge where cmd_valid && cmd_ready.
- FSM states:
  - IDLE: waits for a non-empty FIFO. If non-empty, loads lu_a/lu_b/lu_sel and the tag from the FIFO head, then goes to DRIVE.
  - DRIVE: lu_* are stable for the full cycle. At the edge it captures lu_res into rsp_res, computes rsp_zero, pops the FIFO head, and goes to RESP.
  - RESP: rsp_valid=1. rsp_* are held until rsp_ready. On handshake, op_count increments. If the FIFO is non-empty after the handshake, the head is loaded into lu_* and the FSM goes to DRIVE; otherwise it goes to IDLE.
- lu_* are written only on the IDLE→DRIVE and RESP→DRIVE transitions and hold their value otherwise.
- FIFO is full when the count equals DEPTH. A push and a pop on the same edge are both honoured; the count is unchanged. cmd_ready is derived from the registered count only, with no same-cycle bypass.
- Pointers wrap modulo DEPTH.
- op_count wraps from 16'hFFFF to 0.

## Timing
- Reset (rst high at an edge): FIFO emptied, pointers cleared, state IDLE, lu_a=lu_b=0, lu_sel=0, rsp_valid=0, rsp_res=0, rsp_tag=0, rsp_zero=0, op_count=0, busy=0. cmd_ready=0 while rst is high and 1 in the first cycle after.
- Reset mid-operation: all queued commands and any pending response are discarded, with no partial handshake. A response whose handshake coincides with rst is not counted.
- Latency: command accepted at edge of cycle 0 into an idle, empty block gives lu_* valid in cycle 1 and rsp_valid=1 in cycle 2.
- Throughput with rsp_ready held high: one response every 2 cycles.
- rsp_valid never drops without a handshake, and rsp_* never change while rsp_valid=1 && !rsp_ready.
- The FIFO fills under backpressure. After DEPTH further accepts beyond the command in flight, cmd_ready=0 until the next pop.

## Test plan
- Reset then single command a=64'hF0F0_F0F0_F0F0_F0F0, b=64'hFF00_FF00_FF00_FF00, op=000, tag=3 -> cycle 2: rsp_valid=1, rsp_res=64'hF000_F000_F000_F000, rsp_tag=3, rsp_zero=0, op_count=1 after handshake.
- op=110, a=1 -> rsp_res=64'hFFFF_FFFF_FFFF_FFFF. Then op=110, a=0 -> rsp_res=0, rsp_zero=1.
- Eight back-to-back commands covering ops 000–111 with tags 0–7, rsp_ready=1 -> responses in tag order 0..7, one every 2 cycles, each matching the logic-unit function, op_count=8.
- rsp_ready=0 while pushing 6 commands -> cmd_ready falls after DEPTH+1=5 accepts. Response 0 is held stable. Raising rsp_ready drains all 5 in order.
- rst asserted for one cycle while in RESP with 3 queued -> all outputs return to reset values next cycle, no further responses, and a fresh command completes normally.
- Preload op_count to 16'hFFFF by issuing 65535 ops (or via force), then one more -> op_count=0.
